// File: rtl/exec_datapath_if.sv
// rtl/exec_datapath_if.sv - execute-stage bus between the parent core and exec_datapath
interface exec_datapath_if;
   logic       exec_en;
   logic [7:0] instruction;
   logic [7:0] pc;
   logic [7:0] reg_data_0;
   logic [7:0] reg_data_1;
   logic [7:0] jump_offset;
   logic [1:0] reg_addr_0;
   logic [1:0] reg_addr_1;
   logic [1:0] reg_addr_w;
   logic       reg_w_en;
   logic [7:0] wb_data;
   logic [7:0] pc_next;
   logic       overflow;
   logic       done;

   modport master (
      output exec_en, instruction, pc, reg_data_0, reg_data_1, jump_offset,
      input  reg_addr_0, reg_addr_1, reg_addr_w, reg_w_en, wb_data, pc_next, overflow, done
   );

   modport slave (
      input  exec_en, instruction, pc, reg_data_0, reg_data_1, jump_offset,
      output reg_addr_0, reg_addr_1, reg_addr_w, reg_w_en, wb_data, pc_next, overflow, done
   );
endinterface

// File: rtl/exec_datapath.sv
// rtl/exec_datapath.sv - decode, ALU and data memory for the 8-bit execute/memory stage
module exec_datapath #(
   parameter int DMEM_DEPTH = 256
) (
   input logic             clk,
   input logic             rst,
   exec_datapath_if.slave  bus
);
   localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   logic [7:0] dmem [DMEM_DEPTH];

   logic [3:0] op;
   logic [1:0] fa;
   logic [1:0] fb;
   logic [7:0] a_val;
   logic [7:0] b_val;
   logic [7:0] imm;
   logic [7:0] sum;
   logic [7:0] diff;
   logic [7:0] sum_imm;
   logic [AW-1:0] mem_addr;

   logic [7:0] res;
   logic       ovf;
   logic       wen;
   logic [1:0] waddr;
   logic [7:0] pcn;

   assign op       = bus.instruction[7:4];
   assign fa       = bus.instruction[3:2];
   assign fb       = bus.instruction[1:0];
   assign a_val    = bus.reg_data_0;
   assign b_val    = bus.reg_data_1;
   assign imm      = {{6{fb[1]}}, fb};
   assign sum      = a_val + b_val;
   assign diff     = a_val - b_val;
   assign sum_imm  = a_val + imm;
   assign mem_addr = a_val[AW-1:0];

   assign bus.reg_addr_0 = fa;
   assign bus.reg_addr_1 = fb;

   always_comb begin
      res   = 8'h00;
      ovf   = 1'b0;
      wen   = 1'b1;
      waddr = fa;
      pcn   = bus.pc + 8'd1;
      case (op)
         4'h0: begin
            res = sum;
            ovf = (a_val[7] == b_val[7]) && (sum[7] != a_val[7]);
         end
         4'h1: begin
            res = diff;
            ovf = (a_val[7] != b_val[7]) && (diff[7] != a_val[7]);
         end
         4'h2: res = a_val & b_val;
         4'h3: res = a_val | b_val;
         4'h4: res = a_val ^ b_val;
         4'h5: res = ~(a_val | b_val);
         4'h6: res = a_val << b_val[2:0];
         4'h7: res = a_val >> b_val[2:0];
         4'h8: res = ($signed(a_val) < $signed(b_val)) ? 8'd1 : 8'd0;
         4'h9: begin
            res = sum_imm;
            ovf = (a_val[7] == imm[7]) && (sum_imm[7] != a_val[7]);
         end
         4'hA: begin
            res   = dmem[mem_addr];
            waddr = fb;
         end
         4'hB: wen = 1'b0;
         4'hC: begin
            wen = 1'b0;
            if (a_val == b_val) pcn = bus.pc + bus.jump_offset;
         end
         4'hD: begin
            wen = 1'b0;
            if (a_val != b_val) pcn = bus.pc + bus.jump_offset;
         end
         4'hE: begin
            wen = 1'b0;
            pcn = a_val;
         end
         default: begin
            // jal links the return address into R3
            res   = bus.pc + 8'd1;
            waddr = 2'b11;
            pcn   = a_val;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.reg_addr_w <= 2'b00;
         bus.reg_w_en   <= 1'b0;
         bus.wb_data    <= 8'h00;
         bus.pc_next    <= 8'h00;
         bus.overflow   <= 1'b0;
         bus.done       <= 1'b0;
         for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 8'h00;
      end else begin
         bus.done <= bus.exec_en;
         if (bus.exec_en) begin
            bus.reg_addr_w <= waddr;
            bus.reg_w_en   <= wen;
            bus.wb_data    <= res;
            bus.pc_next    <= pcn;
            bus.overflow   <= ovf;
            if (op == 4'hB) dmem[mem_addr] <= b_val;
         end
      end
   end
endmodule

// File: tb/tb_exec_datapath.sv
// tb/tb_exec_datapath.sv - directed and random checks of exec_datapath against an arithmetic model
module tb_exec_datapath;
   logic clk;
   logic rst;

   exec_datapath_if bus ();

   exec_datapath #(.DMEM_DEPTH(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_asserts = 0;
   int n_fail    = 0;

   int         mem [256];
   logic [7:0] e_wb;
   logic       e_wb_known;
   logic [1:0] e_waddr;
   logic       e_wen;
   logic [7:0] e_pc;
   logic       e_ovf;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from the opcode rules using signed integer arithmetic
   task automatic model(input logic [7:0] ins, input logic [7:0] p, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] off);
      int op, fa, fb, ua, ub, sa, sb, r, sh, up, uo;
      op = int'(ins[7:4]);
      fa = int'(ins[3:2]);
      fb = int'(ins[1:0]);
      ua = int'(av);
      ub = int'(bv);
      up = int'(p);
      uo = int'(off);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      sh = ub % 8;
      r  = 0;
      e_wen      = (op <= 10) || (op == 15);
      e_waddr    = fa[1:0];
      e_pc       = 8'((up + 1) % 256);
      e_ovf      = 1'b0;
      e_wb_known = 1'b1;
      case (op)
         0:  begin r = sa + sb; e_ovf = (r > 127) || (r < -128); end
         1:  begin r = sa - sb; e_ovf = (r > 127) || (r < -128); end
         2:  r = ua & ub;
         3:  r = ua | ub;
         4:  r = ua ^ ub;
         5:  r = 255 - (ua | ub);
         6:  r = (ua * (1 << sh)) % 256;
         7:  r = ua / (1 << sh);
         8:  r = (sa < sb) ? 1 : 0;
         9:  begin r = sa + ((fb >= 2) ? fb - 4 : fb); e_ovf = (r > 127) || (r < -128); end
         10: begin r = mem[ua]; e_waddr = fb[1:0]; end
         11: begin mem[ua] = ub; e_wb_known = 1'b0; end
         12: begin e_wb_known = 1'b0; if (ua == ub) e_pc = 8'((up + uo) % 256); end
         13: begin e_wb_known = 1'b0; if (ua != ub) e_pc = 8'((up + uo) % 256); end
         14: begin e_wb_known = 1'b0; e_pc = av; end
         default: begin r = (up + 1) % 256; e_waddr = 2'd3; e_pc = av; end
      endcase
      e_wb = r[7:0];
   endtask

   task automatic check_outputs(input string tag, input logic done_exp);
      chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, done_exp});
      chk({tag, ".reg_w_en"}, {7'd0, bus.reg_w_en}, {7'd0, e_wen});
      chk({tag, ".reg_addr_w"}, {6'd0, bus.reg_addr_w}, {6'd0, e_waddr});
      chk({tag, ".pc_next"}, bus.pc_next, e_pc);
      chk({tag, ".overflow"}, {7'd0, bus.overflow}, {7'd0, e_ovf});
      if (e_wb_known) chk({tag, ".wb_data"}, bus.wb_data, e_wb);
   endtask

   task automatic exec_op(input string tag, input logic [7:0] ins, input logic [7:0] p,
                          input logic [7:0] av, input logic [7:0] bv, input logic [7:0] off);
      bus.exec_en     = 1'b1;
      bus.instruction = ins;
      bus.pc          = p;
      bus.reg_data_0  = av;
      bus.reg_data_1  = bv;
      bus.jump_offset = off;
      #1;
      chk({tag, ".reg_addr_0"}, {6'd0, bus.reg_addr_0}, {6'd0, ins[3:2]});
      chk({tag, ".reg_addr_1"}, {6'd0, bus.reg_addr_1}, {6'd0, ins[1:0]});
      model(ins, p, av, bv, off);
      @(posedge clk);
      #1;
      bus.exec_en = 1'b0;
      check_outputs(tag, 1'b1);
   endtask

   task automatic idle(input string tag);
      bus.exec_en     = 1'b0;
      bus.instruction = 8'hB0;
      bus.reg_data_0  = 8'($urandom);
      bus.reg_data_1  = 8'($urandom);
      bus.pc          = 8'($urandom);
      @(posedge clk);
      #1;
      check_outputs(tag, 1'b0);
   endtask

   task automatic do_reset(input logic with_sw, input logic [7:0] av, input logic [7:0] bv);
      rst             = 1'b1;
      bus.exec_en     = with_sw;
      bus.instruction = 8'hB0;
      bus.reg_data_0  = av;
      bus.reg_data_1  = bv;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      bus.exec_en = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 0;
      e_wb = 8'h00; e_wb_known = 1'b1; e_waddr = 2'd0; e_wen = 1'b0; e_pc = 8'h00; e_ovf = 1'b0;
      check_outputs("reset", 1'b0);
   endtask

   initial begin
      logic [7:0] ins, av, bv;
      rst             = 1'b1;
      bus.exec_en     = 1'b0;
      bus.instruction = 8'h00;
      bus.pc          = 8'h00;
      bus.reg_data_0  = 8'h00;
      bus.reg_data_1  = 8'h00;
      bus.jump_offset = 8'h00;
      @(posedge clk);
      #1;
      do_reset(1'b0, 8'h00, 8'h00);
      exec_op("lw_after_reset", 8'hA1, 8'h00, 8'h9C, 8'h00, 8'h00);

      exec_op("add_ovf", 8'h06, 8'h10, 8'h7F, 8'h01, 8'h00);
      exec_op("sub", 8'h1B, 8'h11, 8'h05, 8'h07, 8'h00);
      exec_op("slt", 8'h84, 8'h12, 8'hFF, 8'h01, 8'h00);
      exec_op("sll", 8'h69, 8'h13, 8'h81, 8'h01, 8'h00);
      exec_op("sw", 8'hB0, 8'h14, 8'h10, 8'hA5, 8'h00);
      exec_op("lw", 8'hA2, 8'h15, 8'h10, 8'h00, 8'h00);
      exec_op("beq_taken", 8'hC0, 8'h20, 8'h03, 8'h03, 8'hFC);
      exec_op("bne_equal", 8'hD0, 8'h20, 8'h03, 8'h03, 8'hFC);
      exec_op("pc_wrap", 8'h20, 8'hFF, 8'h0F, 8'h3C, 8'h00);
      exec_op("jal", 8'hF0, 8'h0A, 8'h40, 8'h00, 8'h00);
      exec_op("j", 8'hE0, 8'h0B, 8'h55, 8'h00, 8'h00);
      idle("idle_hold");
      exec_op("lw_after_idle", 8'hA3, 8'h30, 8'h10, 8'h00, 8'h00);

      for (int n = 0; n < 400; n++) begin
         ins = 8'($urandom);
         av  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         bv  = ($urandom_range(0, 3) == 0) ? av : 8'($urandom);
         exec_op("rand", ins, 8'($urandom), av, bv, 8'($urandom));
         if ($urandom_range(0, 9) == 0) idle("rand_idle");
      end

      exec_op("sw_pre_reset", 8'hB0, 8'h40, 8'h33, 8'h5A, 8'h00);
      do_reset(1'b1, 8'h33, 8'h77);
      exec_op("lw_post_reset", 8'hA1, 8'h41, 8'h33, 8'h00, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
